// File: rtl/uart_rx_os16_pkg.sv
// ============================================================================
//  uart_rx_os16_pkg : shared UART receiver state encoding and defaults
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_os16_pkg;

  localparam int   c_data_bits_def = 8;
  localparam int   c_os_rate_def   = 16;
  localparam logic c_line_idle     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_os16_sync.sv
// ============================================================================
//  uart_rx_os16_sync : rxd 2-flop synchronizer and baud16 rising-edge tick
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os16_sync
  import uart_rx_os16_pkg::*;
(
  input  logic clk27,
  input  logic rst_n,
  input  logic baud16,
  input  logic rxd,
  output logic rxd_s,
  output logic tick
);

  logic r_rxd_meta;
  logic r_rxd_s;
  logic r_baud_d;

  // Idle-level reset values keep a high baud16 or line from faking an edge
  always_ff @(posedge clk27 or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_meta <= c_line_idle;
      r_rxd_s    <= c_line_idle;
      r_baud_d   <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;
      r_baud_d   <= baud16;
    end
  end

  assign rxd_s = r_rxd_s;
  assign tick  = baud16 & ~r_baud_d;

endmodule

`default_nettype wire

// File: rtl/uart_rx_os16.sv
// ============================================================================
//  uart_rx_os16 : 8N1 UART receiver, 16x oversampled via baud16 clock enable
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int DATA_BITS = c_data_bits_def,
  parameter int OS_RATE   = c_os_rate_def
) (
  input  logic                 clk27,
  input  logic                 rst_n,
  input  logic                 baud16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int c_tick_w = $clog2(OS_RATE);
  localparam int c_bit_w  = $clog2(DATA_BITS + 1);
  localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OS_RATE / 2);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OS_RATE - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

  logic w_rxd_s;
  logic w_tick;

  rx_state_t              r_state,    w_state_nxt;
  logic [c_tick_w-1:0]    r_tick_cnt, w_tick_nxt;
  logic [c_bit_w-1:0]     r_bit_cnt,  w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift,    w_shift_nxt;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_frame_err;
  logic                   w_deliver;
  logic                   w_ferr;
  logic                   w_ack;

  uart_rx_os16_sync u_sync (
    .clk27  (clk27),
    .rst_n  (rst_n),
    .baud16 (baud16),
    .rxd    (rxd),
    .rxd_s  (w_rxd_s),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rxd_s) begin
            w_state_nxt = ST_START;
            w_tick_nxt  = c_tick_w'(1);
          end
        end
        ST_START: begin
          if (r_tick_cnt == c_tick_mid) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_bit_last) w_state_nxt = ST_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_nxt  = '0;
            w_deliver   = w_rxd_s;
            w_ferr      = ~w_rxd_s;
            w_state_nxt = w_rxd_s ? ST_IDLE : ST_BREAK;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // Stay here until the line returns high so a held-low line never restarts
          if (w_rxd_s) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk27 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  assign w_ack = rx_ack & r_valid;

  always_ff @(posedge clk27 or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_deliver && (!r_valid || w_ack)) begin
        r_data    <= w_shift_nxt;
        r_valid   <= 1'b1;
        r_overrun <= 1'b0;
      end else if (w_deliver) begin
        r_overrun <= 1'b1;
      end else if (w_ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_overrun   = r_overrun;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
